// File: rtl/mips_cpu_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit and its ALU.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: ALU op codes (shared with the ALU), FSM state encoding, instruction
// class tags, MIPS opcode/funct field values and the pc_src / alu_src_b mux codes.
package mips_cpu_pkg;

    typedef enum logic [4:0] {
        ALU_AND  = 5'd0,
        ALU_OR   = 5'd1,
        ALU_ADD  = 5'd2,
        ALU_SUB  = 5'd3,
        ALU_SLT  = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SLL  = 5'd6,
        ALU_SRL  = 5'd7,
        ALU_SRA  = 5'd8,
        ALU_SLLV = 5'd9,
        ALU_SRLV = 5'd10,
        ALU_SRAV = 5'd11,
        ALU_LUI  = 5'd12,
        ALU_SLTU = 5'd13
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Sequencing class: decides which states an instruction visits.
    typedef enum logic [2:0] {
        CLS_ALU_R = 3'd0,
        CLS_ALU_I = 3'd1,
        CLS_LOAD  = 3'd2,
        CLS_STORE = 3'd3,
        CLS_BEQ   = 3'd4,
        CLS_BNE   = 3'd5,
        CLS_J     = 3'd6,
        CLS_JR    = 3'd7
    } instr_class_t;

    typedef struct packed {
        alu_op_t      alu_op;
        logic [1:0]   alu_src_b;
        logic         reg_dst;
        instr_class_t cls;
        logic         illegal;
    } dec_t;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // pc_src mux codes
    localparam logic [1:0] PC_SRC_PC4    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_RS     = 2'd3;

    // alu_src_b mux codes
    localparam logic [1:0] ALUB_RT   = 2'd0;
    localparam logic [1:0] ALUB_SEXT = 2'd1;
    localparam logic [1:0] ALUB_ZEXT = 2'd2;

endpackage

// File: rtl/mips_cpu_control_decode.sv
// Combinational instruction classifier: instr -> ALU op, B-mux select, dest select, class.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows instr_i.
//
// Ports:
//   instr_i  in  32  instruction word from the IR
//   dec_o    out dec_t {alu_op, alu_src_b, reg_dst, cls, illegal}
module mips_cpu_control_decode
    import mips_cpu_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [5:0] opcode;
    logic [5:0] funct;
    // Register and immediate fields are the datapath's business, not ours.
    logic       unused_fields;

    assign opcode        = instr_i[31:26];
    assign funct         = instr_i[5:0];
    assign unused_fields = ^instr_i[25:6];

    always_comb begin
        dec_o.alu_op    = ALU_ADD;
        dec_o.alu_src_b = ALUB_RT;
        dec_o.reg_dst   = 1'b0;
        dec_o.cls       = CLS_ALU_I;
        dec_o.illegal   = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                dec_o.cls     = CLS_ALU_R;
                dec_o.reg_dst = 1'b1;
                case (funct)
                    FN_SLL:  dec_o.alu_op = ALU_SLL;
                    FN_SRL:  dec_o.alu_op = ALU_SRL;
                    FN_SRA:  dec_o.alu_op = ALU_SRA;
                    FN_SLLV: dec_o.alu_op = ALU_SLLV;
                    FN_SRLV: dec_o.alu_op = ALU_SRLV;
                    FN_SRAV: dec_o.alu_op = ALU_SRAV;
                    FN_ADDU: dec_o.alu_op = ALU_ADD;
                    FN_SUBU: dec_o.alu_op = ALU_SUB;
                    FN_AND:  dec_o.alu_op = ALU_AND;
                    FN_OR:   dec_o.alu_op = ALU_OR;
                    FN_XOR:  dec_o.alu_op = ALU_XOR;
                    FN_SLT:  dec_o.alu_op = ALU_SLT;
                    FN_SLTU: dec_o.alu_op = ALU_SLTU;
                    FN_JR: begin
                        dec_o.cls     = CLS_JR;
                        dec_o.reg_dst = 1'b0;
                    end
                    default: begin
                        dec_o.illegal = 1'b1;
                        dec_o.reg_dst = 1'b0;
                    end
                endcase
            end
            OP_ADDIU: begin
                dec_o.alu_op    = ALU_ADD;
                dec_o.alu_src_b = ALUB_SEXT;
            end
            OP_SLTI: begin
                dec_o.alu_op    = ALU_SLT;
                dec_o.alu_src_b = ALUB_SEXT;
            end
            OP_SLTIU: begin
                dec_o.alu_op    = ALU_SLTU;
                dec_o.alu_src_b = ALUB_SEXT;
            end
            OP_ANDI: begin
                dec_o.alu_op    = ALU_AND;
                dec_o.alu_src_b = ALUB_ZEXT;
            end
            OP_ORI: begin
                dec_o.alu_op    = ALU_OR;
                dec_o.alu_src_b = ALUB_ZEXT;
            end
            OP_XORI: begin
                dec_o.alu_op    = ALU_XOR;
                dec_o.alu_src_b = ALUB_ZEXT;
            end
            OP_LUI: begin
                dec_o.alu_op    = ALU_LUI;
                dec_o.alu_src_b = ALUB_ZEXT;
            end
            OP_LW: begin
                dec_o.alu_op    = ALU_ADD;
                dec_o.alu_src_b = ALUB_SEXT;
                dec_o.cls       = CLS_LOAD;
            end
            OP_SW: begin
                dec_o.alu_op    = ALU_ADD;
                dec_o.alu_src_b = ALUB_SEXT;
                dec_o.cls       = CLS_STORE;
            end
            OP_BEQ: begin
                dec_o.alu_op = ALU_SUB;
                dec_o.cls    = CLS_BEQ;
            end
            OP_BNE: begin
                dec_o.alu_op = ALU_SUB;
                dec_o.cls    = CLS_BNE;
            end
            OP_J: begin
                dec_o.cls = CLS_J;
            end
            default: begin
                dec_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mips_cpu_control.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing of ALU, muxes and memory strobes.
// Latency: ALU 4, LW 5, SW 4, branch/J/JR 3 cycles with no wait states.
// Backpressure: waitrequest holds FETCH and MEM with strobes frozen; ignored elsewhere.
//
// Ports:
//   clk, reset (sync, active-high)   instr[31:0], zero, waitrequest
//   mem_read, mem_write, mem_addr_sel, ir_write       memory / IR strobes
//   pc_write, pc_src[1:0]                             PC update
//   reg_write, reg_dst, mem_to_reg, alu_src_b[1:0], alu_op[4:0]   datapath
//   illegal (1-cycle pulse in DECODE), active (low once halted), state[2:0] (debug)
module mips_cpu_control
    import mips_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        waitrequest,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic [1:0]  alu_src_b,
    output logic [4:0]  alu_op,
    output logic        illegal,
    output logic        active,
    output logic [2:0]  state
);

    state_t  state_q, state_d;
    alu_op_t alu_op_q, alu_op_d;
    dec_t    dec;
    logic    rs_is_zero;

    mips_cpu_control_decode u_decode (
        .instr_i (instr),
        .dec_o   (dec)
    );

    // JR $0 is the halt idiom.
    assign rs_is_zero = (instr[25:21] == 5'd0);

    assign state  = state_q;
    assign active = (state_q != ST_HALT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            alu_op_q <= ALU_AND;
        end else begin
            state_q  <= state_d;
            alu_op_q <= alu_op_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        alu_op_d     = alu_op_q;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_PC4;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src_b    = ALUB_RT;
        illegal      = 1'b0;
        // Outside EXEC the ALU keeps the last executed op so MEM/WB see a stable result.
        alu_op       = alu_op_q;

        case (state_q)
            ST_FETCH: begin
                mem_read = 1'b1;
                ir_write = 1'b1;
                if (!waitrequest) begin
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end
            end

            ST_DECODE: begin
                if (dec.illegal) begin
                    illegal = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                alu_op    = dec.alu_op;
                alu_op_d  = dec.alu_op;
                alu_src_b = dec.alu_src_b;
                case (dec.cls)
                    CLS_BEQ: begin
                        pc_write = zero;
                        pc_src   = PC_SRC_BRANCH;
                        state_d  = ST_FETCH;
                    end
                    CLS_BNE: begin
                        pc_write = !zero;
                        pc_src   = PC_SRC_BRANCH;
                        state_d  = ST_FETCH;
                    end
                    CLS_J: begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_JUMP;
                        state_d  = ST_FETCH;
                    end
                    CLS_JR: begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_RS;
                        state_d  = rs_is_zero ? ST_HALT : ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    default:             state_d = ST_WB;
                endcase
                // An IR that changed to garbage after DECODE must not reach WB.
                if (dec.illegal) begin
                    state_d = ST_FETCH;
                end
            end

            ST_MEM: begin
                mem_addr_sel = 1'b1;
                alu_src_b    = dec.alu_src_b;
                mem_read     = (dec.cls == CLS_LOAD);
                mem_write    = (dec.cls == CLS_STORE);
                if (!waitrequest) begin
                    state_d = (dec.cls == CLS_LOAD) ? ST_WB : ST_FETCH;
                end
            end

            ST_WB: begin
                reg_write  = 1'b1;
                reg_dst    = dec.reg_dst;
                mem_to_reg = (dec.cls == CLS_LOAD);
                alu_src_b  = dec.alu_src_b;
                state_d    = ST_FETCH;
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_cpu_control.sv
// Scoreboard bench for mips_cpu_control: per-cycle expected output vectors are queued as stimulus is
// driven and compared against the DUT half a cycle later, under a care mask for don't-care fields.
module tb_mips_cpu_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        waitrequest;
    logic        mem_read, mem_write, mem_addr_sel, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        reg_write, reg_dst, mem_to_reg;
    logic [1:0]  alu_src_b;
    logic [4:0]  alu_op;
    logic        illegal, active;
    logic [2:0]  state;

    always #5 clk = ~clk;

    mips_cpu_control dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .zero         (zero),
        .waitrequest  (waitrequest),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr_sel (mem_addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .reg_dst      (reg_dst),
        .mem_to_reg   (mem_to_reg),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .illegal      (illegal),
        .active       (active),
        .state        (state)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       mr, mw, mas, irw, pcw;
        logic [1:0] pcs;
        logic       rw, rd, m2r;
        logic [1:0] asb;
        logic [4:0] aop;
        logic       ill, act;
    } obs_t;

    typedef struct {
        obs_t  exp;
        obs_t  care;
        string tag;
    } sb_t;

    sb_t   sb_q[$];
    int    errors = 0;
    int    checks = 0;
    string cur_test;

    obs_t c_full, c_ctl, c_exec_noaop, c_hold;

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_H = 3'd5;

    function automatic obs_t e_fetch(input logic w);
        obs_t o = '0;
        o.st = S_F; o.mr = 1'b1; o.irw = 1'b1; o.pcw = !w; o.act = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_decode(input logic ill);
        obs_t o = '0;
        o.st = S_D; o.ill = ill; o.act = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_exec(input logic [4:0] aop, input logic [1:0] asb,
                                    input logic pcw, input logic [1:0] pcs);
        obs_t o = '0;
        o.st = S_E; o.aop = aop; o.asb = asb; o.pcw = pcw; o.pcs = pcs; o.act = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_mem(input logic [4:0] aop, input logic mr, input logic mw);
        obs_t o = '0;
        o.st = S_M; o.aop = aop; o.mas = 1'b1; o.mr = mr; o.mw = mw; o.act = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_wb(input logic [4:0] aop, input logic rd, input logic m2r);
        obs_t o = '0;
        o.st = S_W; o.aop = aop; o.rw = 1'b1; o.rd = rd; o.m2r = m2r; o.act = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_halt();
        obs_t o = '0;
        o.st = S_H;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st = state; o.mr = mem_read; o.mw = mem_write; o.mas = mem_addr_sel;
        o.irw = ir_write; o.pcw = pc_write; o.pcs = pc_src; o.rw = reg_write;
        o.rd = reg_dst; o.m2r = mem_to_reg; o.asb = alu_src_b; o.aop = alu_op;
        o.ill = illegal; o.act = active;
        return o;
    endfunction

    // One clock cycle: drive inputs after the falling edge, queue the expectation, compare 1ns later.
    task automatic step(input logic rst, input logic w, input logic z,
                        input obs_t e, input obs_t c, input string tag);
        sb_t  ent;
        obs_t got;
        @(negedge clk);
        reset       = rst;
        waitrequest = w;
        zero        = z;
        ent.exp = e; ent.care = c; ent.tag = tag;
        sb_q.push_back(ent);
        #1;
        ent = sb_q.pop_front();
        got = sample();
        checks++;
        if (((got ^ ent.exp) & ent.care) !== '0) begin
            errors++;
            $display("FAIL %s/%s: got=%06h expected=%06h care=%06h", cur_test, ent.tag, got, ent.exp, ent.care);
        end
    endtask

    task automatic test_reset();
        cur_test = "reset";
        instr = 32'h0000_0000; zero = 1'b0; waitrequest = 1'b1; reset = 1'b1;
        repeat (2) @(posedge clk);
        step(1'b0, 1'b1, 1'b0, e_fetch(1'b1), c_full, "after_reset");
        step(1'b0, 1'b1, 1'b0, e_fetch(1'b1), c_full, "fetch_stall");
    endtask

    task automatic test_addu();
        cur_test = "addu";
        instr = 32'h0022_1821;
        step(1'b0, 1'b0, 1'b0, e_fetch(1'b0), c_ctl, "fetch");
        step(1'b0, 1'b0, 1'b0, e_decode(1'b0), c_ctl, "decode");
        step(1'b0, 1'b1, 1'b0, e_exec(5'd2, 2'd0, 1'b0, 2'd0), c_full, "exec");
        step(1'b0, 1'b1, 1'b0, e_wb(5'd2, 1'b1, 1'b0), c_hold, "wb");
        step(1'b0, 1'b1, 1'b0, e_fetch(1'b1), c_ctl, "cycle5_fetch");
    endtask

    task automatic test_lw_stall();
        cur_test = "lw";
        instr = 32'h8C22_0004;
        step(1'b0, 1'b0, 1'b0, e_fetch(1'b0), c_ctl, "fetch");
        step(1'b0, 1'b0, 1'b0, e_decode(1'b0), c_ctl, "decode");
        step(1'b0, 1'b0, 1'b0, e_exec(5'd2, 2'd1, 1'b0, 2'd0), c_full, "exec");
        step(1'b0, 1'b1, 1'b0, e_mem(5'd2, 1'b1, 1'b0), c_hold, "mem_wait1");
        step(1'b0, 1'b1, 1'b0, e_mem(5'd2, 1'b1, 1'b0), c_hold, "mem_wait2");
        step(1'b0, 1'b0, 1'b0, e_mem(5'd2, 1'b1, 1'b0), c_hold, "mem_done");
        step(1'b0, 1'b0, 1'b0, e_wb(5'd2, 1'b0, 1'b1), c_hold, "wb");
        step(1'b0, 1'b1, 1'b0, e_fetch(1'b1), c_ctl, "cycle8_fetch");
    endtask

    task automatic test_sw();
        cur_test = "sw";
        instr = 32'hAC22_0008;
        step(1'b0, 1'b0, 1'b0, e_fetch(1'b0), c_ctl, "fetch");
        step(1'b0, 1'b0, 1'b0, e_decode(1'b0), c_ctl, "decode");
        step(1'b0, 1'b0, 1'b0, e_exec(5'd2, 2'd1, 1'b0, 2'd0), c_full, "exec");
        step(1'b0, 1'b0, 1'b0, e_mem(5'd2, 1'b0, 1'b1), c_hold, "mem");
        step(1'b0, 1'b1, 1'b0, e_fetch(1'b1), c_ctl, "cycle5_fetch");
    endtask

    task automatic test_branches();
        logic [31:0] br_tab [4] = '{32'h1022_0003, 32'h1022_0003, 32'h1422_0003, 32'h1422_0003};
        logic        z_tab  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic        tk_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            cur_test = $sformatf("branch%0d", i);
            instr = br_tab[i];
            step(1'b0, 1'b0, 1'b0, e_fetch(1'b0), c_ctl, "fetch");
            step(1'b0, 1'b0, 1'b0, e_decode(1'b0), c_ctl, "decode");
            step(1'b0, 1'b0, z_tab[i], e_exec(5'd3, 2'd0, tk_tab[i], 2'd1), c_full, "exec");
            step(1'b0, 1'b1, 1'b0, e_fetch(1'b1), c_ctl, "fetch_after");
        end
    endtask

    task automatic test_alu_ops();
        logic [31:0] in_tab  [4] = '{32'h3422_00FF, 32'h2C22_00FF, 32'h0022_1807, 32'h3C02_1234};
        logic [4:0]  aop_tab [4] = '{5'd1, 5'd13, 5'd11, 5'd12};
        logic [1:0]  asb_tab [4] = '{2'd2, 2'd1, 2'd0, 2'd2};
        logic        rd_tab  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        obs_t        c_exec_op;
        for (int i = 0; i < 4; i++) begin
            cur_test = $sformatf("aluop%0d", i);
            instr = in_tab[i];
            // LUI's B-mux select is not pinned down; only its ALU op is checked.
            c_exec_op = c_full;
            if (i == 3) c_exec_op.asb = '0;
            step(1'b0, 1'b1, 1'b0, e_fetch(1'b1), c_ctl, "fetch_stall");
            step(1'b0, 1'b0, 1'b0, e_fetch(1'b0), c_ctl, "fetch");
            step(1'b0, 1'b0, 1'b0, e_decode(1'b0), c_ctl, "decode");
            step(1'b0, 1'b0, 1'b0, e_exec(aop_tab[i], asb_tab[i], 1'b0, 2'd0), c_exec_op, "exec");
            step(1'b0, 1'b0, 1'b0, e_wb(aop_tab[i], rd_tab[i], 1'b0), c_hold, "wb");
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad_tab [2] = '{32'hFC00_0000, 32'h0022_1801};
        for (int i = 0; i < 2; i++) begin
            cur_test = $sformatf("illegal%0d", i);
            instr = bad_tab[i];
            step(1'b0, 1'b0, 1'b0, e_fetch(1'b0), c_ctl, "fetch");
            step(1'b0, 1'b0, 1'b0, e_decode(1'b1), c_ctl, "decode");
            step(1'b0, 1'b1, 1'b0, e_fetch(1'b1), c_ctl, "back_to_fetch");
        end
    endtask

    task automatic test_jumps();
        cur_test = "j";
        instr = 32'h0800_0010;
        step(1'b0, 1'b0, 1'b0, e_fetch(1'b0), c_ctl, "fetch");
        step(1'b0, 1'b0, 1'b0, e_decode(1'b0), c_ctl, "decode");
        step(1'b0, 1'b0, 1'b0, e_exec(5'd0, 2'd0, 1'b1, 2'd2), c_exec_noaop, "exec");
        step(1'b0, 1'b1, 1'b0, e_fetch(1'b1), c_ctl, "fetch_after");
        cur_test = "jr31";
        instr = 32'h03E0_0008;
        step(1'b0, 1'b0, 1'b0, e_fetch(1'b0), c_ctl, "fetch");
        step(1'b0, 1'b0, 1'b0, e_decode(1'b0), c_ctl, "decode");
        step(1'b0, 1'b0, 1'b0, e_exec(5'd0, 2'd0, 1'b1, 2'd3), c_exec_noaop, "exec");
        step(1'b0, 1'b1, 1'b0, e_fetch(1'b1), c_ctl, "fetch_after");
    endtask

    task automatic test_reset_mid_sw();
        cur_test = "sw_reset";
        instr = 32'hAC22_0008;
        step(1'b0, 1'b0, 1'b0, e_fetch(1'b0), c_ctl, "fetch");
        step(1'b0, 1'b0, 1'b0, e_decode(1'b0), c_ctl, "decode");
        step(1'b0, 1'b0, 1'b0, e_exec(5'd2, 2'd1, 1'b0, 2'd0), c_full, "exec");
        step(1'b0, 1'b1, 1'b0, e_mem(5'd2, 1'b0, 1'b1), c_hold, "mem_stall");
        step(1'b1, 1'b1, 1'b0, e_mem(5'd2, 1'b0, 1'b1), c_hold, "mem_reset_req");
        step(1'b0, 1'b1, 1'b0, e_fetch(1'b1), c_full, "after_reset");
    endtask

    task automatic test_halt();
        cur_test = "halt";
        instr = 32'h0000_0008;
        step(1'b0, 1'b0, 1'b0, e_fetch(1'b0), c_ctl, "fetch");
        step(1'b0, 1'b0, 1'b0, e_decode(1'b0), c_ctl, "decode");
        step(1'b0, 1'b0, 1'b0, e_exec(5'd0, 2'd0, 1'b1, 2'd3), c_exec_noaop, "exec");
        step(1'b0, 1'b0, 1'b0, e_halt(), c_ctl, "halt1");
        instr = 32'h0022_1821;
        step(1'b0, 1'b1, 1'b1, e_halt(), c_ctl, "halt2");
        step(1'b0, 1'b0, 1'b0, e_halt(), c_ctl, "halt3");
        step(1'b1, 1'b0, 1'b0, e_halt(), c_ctl, "halt_reset_req");
        step(1'b0, 1'b1, 1'b0, e_fetch(1'b1), c_full, "after_reset");
    endtask

    initial begin
        c_full           = '1;
        c_ctl            = '1; c_ctl.aop = '0; c_ctl.asb = '0;
        c_exec_noaop     = '1; c_exec_noaop.aop = '0;
        c_hold           = '1; c_hold.asb = '0;

        test_reset();
        test_addu();
        test_lw_stall();
        test_sw();
        test_branches();
        test_alu_ops();
        test_illegal();
        test_jumps();
        test_reset_mid_sw();
        test_halt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
